// File: rtl/isa_pkg.sv
// Shared types and encodings for the ISA bus initiator: FSM states, strobe
// selection from the {io,write} cycle type, and the read value reported on timeout.
package isa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_CMD  = 3'd2,
        ST_WAIT = 3'd3,
        ST_HOLD = 3'd4
    } isa_state_e;

    // Strobe index is the cycle type {io,write} used directly as a bit position.
    localparam int STB_MEMR = 0;
    localparam int STB_MEMW = 1;
    localparam int STB_IOR  = 2;
    localparam int STB_IOW  = 3;

    localparam logic [7:0] RDATA_TIMEOUT = 8'hFF;

    typedef struct packed {
        logic        write;
        logic        io;
        logic [19:0] addr;
        logic [7:0]  wdata;
    } isa_req_t;

    function automatic logic [3:0] strobe_onehot(input logic io, input logic write);
        return 4'b0001 << {io, write};
    endfunction

endpackage

// File: rtl/isa_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset and a selectable
// reset value, for bringing the card's ready line into the clk domain.
module isa_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_l,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/isa_bus_initiator.sv
// Host-side ISA initiator: one byte request in, one ISA I/O or memory cycle out
// (address phase, command strobe, ready wait states, hold), one response back.
module isa_bus_initiator
    import isa_pkg::*;
#(
    parameter int T_ADDR      = 1,
    parameter int T_CMD       = 3,
    parameter int T_HOLD      = 1,
    parameter int RDY_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_io,
    input  logic [19:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        resp_valid,
    output logic [7:0]  resp_rdata,
    output logic        resp_timeout,
    output logic [19:0] bus_a,
    output logic        bus_ale,
    output logic        bus_aen,
    output logic        bus_ior_l,
    output logic        bus_iow_l,
    output logic        bus_memr_l,
    output logic        bus_memw_l,
    output logic [7:0]  bus_d_out,
    output logic        bus_d_oe,
    input  logic [7:0]  bus_d_in,
    input  logic        bus_rdy
);

    localparam int MAX_AC = (T_ADDR > T_CMD) ? T_ADDR : T_CMD;
    localparam int MAX_HR = (T_HOLD > RDY_TIMEOUT) ? T_HOLD : RDY_TIMEOUT;
    localparam int MAX_P  = (MAX_AC > MAX_HR) ? MAX_AC : MAX_HR;
    localparam int CW     = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] ADDR_LAST = CW'(T_ADDR - 1);
    localparam logic [CW-1:0] CMD_LAST  = CW'(T_CMD - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(RDY_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_SAT   = '1;

    isa_state_e      r_state;
    logic [CW-1:0]   r_cnt;
    isa_req_t        r_req;
    logic            r_ready;
    logic [7:0]      r_rdata;
    logic            r_timeout;

    logic            w_rdy_s;
    logic            w_accept;
    logic            w_cmd_end;
    logic            w_wait_to;
    logic            w_release;
    logic            w_strobe_on;
    logic [3:0]      w_stb;

    isa_sync2 #(.RST_VAL(1'b1)) u_rdy_sync (
        .clk     (clk),
        .reset_l (reset_l),
        .i_d     (bus_rdy),
        .o_q     (w_rdy_s)
    );

    assign w_accept  = (r_state == ST_IDLE) && req_valid && r_ready;
    assign w_cmd_end = (r_state == ST_CMD) && (r_cnt == CMD_LAST);
    assign w_wait_to = (r_state == ST_WAIT) && !w_rdy_s && (r_cnt == TO_LAST);
    // Strobe is released on this edge: either ready at end of CMD, ready in WAIT, or timeout.
    assign w_release = (w_cmd_end && w_rdy_s) ||
                       ((r_state == ST_WAIT) && (w_rdy_s || (r_cnt == TO_LAST)));

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_req   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_cnt <= (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CW'(1);
            case (r_state)
                ST_IDLE: begin
                    r_cnt   <= '0;
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_req.write <= req_write;
                        r_req.io    <= req_io;
                        r_req.addr  <= req_io ? {4'h0, req_addr[15:0]} : req_addr;
                        r_req.wdata <= req_wdata;
                        r_ready     <= 1'b0;
                        r_state     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (r_cnt == ADDR_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (w_cmd_end) begin
                        r_cnt   <= '0;
                        r_state <= w_rdy_s ? ST_HOLD : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_release) begin
                        r_cnt   <= '0;
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Read data and timeout flag are captured on the strobe-release edge and held.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_rdata   <= 8'h00;
            r_timeout <= 1'b0;
        end else if (w_release) begin
            r_timeout <= w_wait_to;
            if (w_wait_to)
                r_rdata <= RDATA_TIMEOUT;
            else if (!r_req.write)
                r_rdata <= bus_d_in;
        end
    end

    assign w_strobe_on = (r_state == ST_CMD) || (r_state == ST_WAIT);
    assign w_stb       = strobe_onehot(r_req.io, r_req.write) & {4{w_strobe_on}};

    assign req_ready    = r_ready;
    assign resp_valid   = (r_state == ST_HOLD) && (r_cnt == HOLD_LAST);
    assign resp_rdata   = r_rdata;
    assign resp_timeout = r_timeout;

    assign bus_a      = r_req.addr;
    assign bus_aen    = (r_state == ST_IDLE);
    assign bus_ale    = (r_state == ST_ADDR) && (r_cnt == '0);
    assign bus_memr_l = ~w_stb[STB_MEMR];
    assign bus_memw_l = ~w_stb[STB_MEMW];
    assign bus_ior_l  = ~w_stb[STB_IOR];
    assign bus_iow_l  = ~w_stb[STB_IOW];
    assign bus_d_out  = r_req.wdata;
    assign bus_d_oe   = r_req.write && (r_state != ST_IDLE);

endmodule

// File: tb/tb_isa_bus_initiator.sv
// Scoreboard bench for isa_bus_initiator: the driver queues the expected response
// of each accepted request, a negedge monitor checks strobes and responses.
module tb_isa_bus_initiator;

    logic        clk = 1'b0;
    logic        reset_l;
    logic        req_valid, req_ready, req_write, req_io;
    logic [19:0] req_addr;
    logic [7:0]  req_wdata;
    logic        resp_valid, resp_timeout;
    logic [7:0]  resp_rdata;
    logic [19:0] bus_a;
    logic        bus_ale, bus_aen, bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l;
    logic [7:0]  bus_d_out, bus_d_in, card_data;
    logic        bus_d_oe, bus_rdy;

    always #5 clk = ~clk;

    isa_bus_initiator dut (
        .clk(clk), .reset_l(reset_l),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_io(req_io), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_timeout(resp_timeout),
        .bus_a(bus_a), .bus_ale(bus_ale), .bus_aen(bus_aen),
        .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l),
        .bus_memr_l(bus_memr_l), .bus_memw_l(bus_memw_l),
        .bus_d_out(bus_d_out), .bus_d_oe(bus_d_oe), .bus_d_in(bus_d_in),
        .bus_rdy(bus_rdy)
    );

    // Card model: drives its data only while a read strobe is low.
    assign bus_d_in = (!bus_memr_l || !bus_ior_l) ? card_data : 8'h00;

    // Strobe one-hot as {ior,iow,memr,memw} active high.
    localparam logic [3:0] S_IOR = 4'b1000, S_IOW = 4'b0100, S_MEMR = 4'b0010, S_MEMW = 4'b0001;

    typedef struct {
        logic        chk_rd;
        logic [7:0]  rdata;
        logic        tmo;
        logic [3:0]  stb;
        logic [19:0] a;
        logic        doe;
        logic [7:0]  dout;
        int          len_min;
        int          len_max;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        vectors++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic exp_t mk(input logic chk_rd, input logic [7:0] rd, input logic tmo,
                                input logic [3:0] stb, input logic [19:0] a, input logic doe,
                                input logic [7:0] dout, input int lmin, input int lmax,
                                input int lat);
        exp_t e;
        e.chk_rd = chk_rd; e.rdata = rd; e.tmo = tmo; e.stb = stb; e.a = a;
        e.doe = doe; e.dout = dout; e.len_min = lmin; e.len_max = lmax; e.lat = lat;
        e.acc = 0;
        return e;
    endfunction

    // Monitor: strobe tracking, bus invariants, response scoreboard.
    logic [3:0]  stbv;
    logic        in_stb = 1'b0;
    int          cur_len = 0, last_len = 0;
    logic [3:0]  cur_stb, last_stb;
    logic [19:0] cur_a, last_a;
    logic        cur_doe, last_doe;
    logic [7:0]  cur_dout, last_dout;

    assign stbv = ~{bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l};

    always @(negedge clk) begin
        if (reset_l) begin
            if ($countones(stbv) > 1 || (stbv != 4'h0 && (bus_ale || bus_aen))) begin
                errors++;
                $display("FAIL strobe_rule: strobes=%b ale=%b aen=%b", stbv, bus_ale, bus_aen);
            end
            if (q.size() > 0 && req_ready) begin
                errors++;
                $display("FAIL ready_busy: req_ready=1 with %0d outstanding", q.size());
            end
            if (stbv != 4'h0) begin
                if (!in_stb) begin
                    cur_len = 1; cur_stb = stbv; cur_a = bus_a;
                    cur_doe = bus_d_oe; cur_dout = bus_d_out;
                end else cur_len++;
                in_stb = 1'b1;
            end else if (in_stb) begin
                in_stb = 1'b0;
                last_len = cur_len; last_stb = cur_stb; last_a = cur_a;
                last_doe = cur_doe; last_dout = cur_dout;
            end
            if (resp_valid) begin
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp: resp_valid with empty scoreboard");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("resp_timeout", 32'(resp_timeout), 32'(e.tmo));
                    if (e.chk_rd) chk("resp_rdata", 32'(resp_rdata), 32'(e.rdata));
                    chk("strobe_sel", 32'(last_stb), 32'(e.stb));
                    chk_rng("strobe_len", last_len, e.len_min, e.len_max);
                    chk("bus_a", 32'(last_a), 32'(e.a));
                    chk("d_oe", 32'(last_doe), 32'(e.doe));
                    if (e.doe) chk("d_out", 32'(last_dout), 32'(e.dout));
                    if (e.lat != 0) chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic io, input logic [19:0] addr,
                         input logic [7:0] wd, input exp_t e, input bit keep);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_io = io; req_addr = addr; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'(req_ready), 32'd1);
        end else begin
            e.acc = cyc;
            @(posedge clk);
            q.push_back(e);
        end
        #1;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_strobe(input logic [3:0] s);
        int n;
        n = 0;
        while ((stbv & s) == 4'h0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("strobe_seen", 32'((stbv & s) != 4'h0), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_l = 1'b0; bus_rdy = 1'b1; card_data = 8'h00;
        req_valid = 1'b0; req_write = 1'b0; req_io = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready_resp", 32'({req_ready, resp_valid, resp_timeout}), 32'd0);
        chk("rst_rdata", 32'(resp_rdata), 32'd0);
        chk("rst_bus_a", 32'(bus_a), 32'd0);
        chk("rst_ale_aen", 32'({bus_ale, bus_aen}), 32'b01);
        chk("rst_strobes", 32'({bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l}), 32'hF);
        chk("rst_dout_oe", 32'({bus_d_out, bus_d_oe}), 32'd0);
        reset_l = 1'b1;

        // IO write 0x3D4 <- 0x0E, no wait states.
        issue(1, 1, 20'h003D4, 8'h0E, mk(0, 8'h00, 0, S_IOW, 20'h003D4, 1, 8'h0E, 3, 3, 6), 0);
        wait_idle();

        // Memory read 0xB8000, card returns 0x41.
        card_data = 8'h41;
        issue(0, 0, 20'hB8000, 8'h00, mk(1, 8'h41, 0, S_MEMR, 20'hB8000, 0, 8'h00, 3, 3, 6), 0);
        wait_idle();

        // IO read 0x3DA (upper address bits must be dropped) with rdy low 10 cycles.
        card_data = 8'h09;
        bus_rdy = 1'b0;
        repeat (4) @(negedge clk);
        fork
            issue(0, 1, 20'hF03DA, 8'h00, mk(1, 8'h09, 0, S_IOR, 20'h003DA, 0, 8'h00, 13, 16, 0), 0);
            begin
                wait_strobe(S_IOR);
                repeat (10) @(posedge clk);
                #1 bus_rdy = 1'b1;
            end
        join
        wait_idle();

        // Memory write with rdy stuck low: forced end after 64 wait cycles.
        bus_rdy = 1'b0;
        repeat (4) @(negedge clk);
        issue(1, 0, 20'hA0010, 8'h55, mk(1, 8'hFF, 1, S_MEMW, 20'hA0010, 1, 8'h55, 67, 67, 70), 0);
        wait_idle();
        bus_rdy = 1'b1;
        repeat (4) @(negedge clk);

        // Back-to-back with req_valid held high.
        card_data = 8'h3C;
        issue(1, 1, 20'h00080, 8'hA5, mk(0, 8'h00, 0, S_IOW, 20'h00080, 1, 8'hA5, 3, 3, 6), 1);
        issue(0, 1, 20'h00081, 8'h00, mk(1, 8'h3C, 0, S_IOR, 20'h00081, 0, 8'h00, 3, 3, 6), 1);
        issue(1, 0, 20'h00400, 8'h5A, mk(0, 8'h00, 0, S_MEMW, 20'h00400, 1, 8'h5A, 3, 3, 6), 0);
        wait_idle();

        // Reset asserted while the strobe is held low in WAIT.
        bus_rdy = 1'b0;
        repeat (4) @(negedge clk);
        issue(1, 0, 20'hC0000, 8'h99, mk(0, 8'h00, 0, S_MEMW, 20'hC0000, 1, 8'h99, 3, 3, 6), 0);
        wait_strobe(S_MEMW);
        repeat (8) @(posedge clk);
        #2 reset_l = 1'b0;
        q.delete();
        #1;
        chk("abort_strobes", 32'({bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l}), 32'hF);
        chk("abort_oe_aen", 32'({bus_d_oe, bus_aen}), 32'b01);
        chk("abort_resp", 32'({resp_valid, req_ready}), 32'd0);
        repeat (3) @(negedge clk);
        bus_rdy = 1'b1;
        reset_l = 1'b1;
        card_data = 8'h7E;
        issue(0, 0, 20'h12345, 8'h00, mk(1, 8'h7E, 0, S_MEMR, 20'h12345, 0, 8'h00, 3, 3, 6), 0);
        wait_idle();
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
